cim_exec_unit: RTL and testbench

Multi-cycle, multi-bank execution unit for CIM-type instructions (opcode 7'b11111_11). It sits between the core's decode stage and NBANKS compute-in-memory macros. It replaces the single-cycle combinational CIM strobes with a valid/ready issue port, a per-bank request/acknowledge handshake, a registered writeback port and a new burst-compute mode. The core stalls its pipeline (HLT) while OP_VALID is high and OP_READY is low.

---
 rtl/cim_exec_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_cim_exec_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_exec_unit.sv
// CIM execution unit: valid/ready issue, per-bank req/ack, registered writeback, burst compute.
// Latency: write 1 cycle REQ (+wait states), read adds one WB cycle; OP_READY low outside IDLE.
module cim_exec_unit #(
  parameter int XLEN    = 32,
  parameter int NBANKS  = 4,
  parameter int BANK_AW = 12,
  parameter int OREG_W  = 4
) (
  input  logic                     CLK,
  input  logic                     RES,
  input  logic                     OP_VALID,
  output logic                     OP_READY,
  input  logic [2:0]               OP_FCT3,
  input  logic [XLEN-1:0]          OP_RS1,
  input  logic [XLEN-1:0]          OP_RS2,
  input  logic [4:0]               OP_RD,
  output logic                     WB_VALID,
  output logic [4:0]               WB_RD,
  output logic [XLEN-1:0]          WB_DATA,
  output logic                     ERR,
  output logic [NBANKS-1:0]        CIM_REQ,
  input  logic [NBANKS-1:0]        CIM_ACK,
  output logic                     CIM_WRITE,
  output logic                     CIM_COMP,
  output logic                     CIM_PSUM,
  output logic                     CIM_RST,
  output logic [OREG_W-1:0]        CIM_OREG,
  output logic [BANK_AW-1:0]       CIM_ADDR,
  output logic [XLEN-1:0]          CIM_DIN,
  input  logic [NBANKS*XLEN-1:0]   CIM_DOUT
);

  localparam int BW = $clog2(NBANKS);

  localparam logic [2:0] F_WR      = 3'b000;
  localparam logic [2:0] F_COMP    = 3'b001;
  localparam logic [2:0] F_RD      = 3'b010;
  localparam logic [2:0] F_REG_RD  = 3'b011;
  localparam logic [2:0] F_REG_RST = 3'b100;
  localparam logic [2:0] F_BURST   = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB, S_ERR} state_t;

  typedef struct packed {
    logic write;
    logic comp;
    logic psum;
    logic rst;
  } strb_t;

  state_t              r_state;
  logic                r_ready;
  logic [BW-1:0]       r_bank;
  logic [NBANKS-1:0]   r_req;
  strb_t               r_strb;
  logic [OREG_W-1:0]   r_oreg;
  logic [BANK_AW-1:0]  r_addr;
  logic [XLEN-1:0]     r_din;
  logic                r_is_read;
  logic [4:0]          r_rd;
  logic [7:0]          r_cnt;
  logic                r_wb_vld;
  logic [4:0]          r_wb_rd;
  logic [XLEN-1:0]     r_wb_data;
  logic                r_err;

  logic                w_legal;
  logic                w_is_read;
  strb_t               w_strb;
  logic [OREG_W-1:0]   w_oreg;
  logic [XLEN-1:0]     w_src;
  logic [7:0]          w_cnt;
  logic [BW-1:0]       w_bank;
  logic [BANK_AW-1:0]  w_addr;
  logic                w_ack;
  logic [XLEN-1:0]     w_dout;
  logic                w_unused;

  // Decode of the instruction presented on the issue port
  always_comb begin
    w_legal   = 1'b1;
    w_is_read = 1'b0;
    w_strb    = '0;
    w_oreg    = '0;
    w_src     = OP_RS2;
    w_cnt     = '0;
    case (OP_FCT3)
      F_WR: w_strb.write = 1'b1;
      F_COMP: begin
        w_strb.comp = 1'b1;
        w_strb.psum = 1'b1;
      end
      F_RD: begin
        w_src     = OP_RS1;
        w_is_read = 1'b1;
      end
      F_REG_RD: begin
        w_oreg      = OP_RS1[OREG_W-1:0];
        w_strb.comp = 1'b1;
        w_is_read   = 1'b1;
      end
      F_REG_RST: begin
        w_strb.comp = 1'b1;
        w_strb.rst  = 1'b1;
      end
      F_BURST: begin
        w_strb.comp = 1'b1;
        w_strb.psum = 1'b1;
        w_cnt       = OP_RS2[XLEN-1 -: 8];
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_bank = w_src[BANK_AW +: BW];
  assign w_addr = w_src[BANK_AW-1:0];

  // Only the selected bank's ack and read data are observed
  always_comb begin
    w_ack  = 1'b0;
    w_dout = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (r_bank == BW'(b)) begin
        w_ack  = CIM_ACK[b];
        w_dout = CIM_DOUT[b*XLEN +: XLEN];
      end
    end
  end

  assign w_unused = &{1'b0, OP_RS1, OP_RS2};

  always_ff @(posedge CLK) begin
    if (!RES) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b0;
      r_bank    <= '0;
      r_req     <= '0;
      r_strb    <= '0;
      r_oreg    <= '0;
      r_addr    <= '0;
      r_din     <= '0;
      r_is_read <= 1'b0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_wb_vld  <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wb_vld <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (OP_VALID && r_ready) begin
            r_ready <= 1'b0;
            if (w_legal) begin
              r_state   <= S_ISSUE;
              r_bank    <= w_bank;
              r_req     <= NBANKS'(1) << w_bank;
              r_strb    <= w_strb;
              r_oreg    <= w_oreg;
              r_addr    <= w_addr;
              r_din     <= OP_RS1;
              r_is_read <= w_is_read;
              r_rd      <= OP_RD;
              r_cnt     <= w_cnt;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (w_ack) begin
            if (r_cnt != 8'd0) begin
              // Burst beat: bank fixed, local address wraps within the bank
              r_addr <= r_addr + BANK_AW'(1);
              r_cnt  <= r_cnt - 8'd1;
            end else begin
              r_req  <= '0;
              r_strb <= '0;
              r_oreg <= '0;
              if (r_is_read && (r_rd != 5'd0)) begin
                r_state   <= S_WB;
                r_wb_vld  <= 1'b1;
                r_wb_rd   <= r_rd;
                r_wb_data <= w_dout;
              end else begin
                r_state <= S_IDLE;
                r_ready <= 1'b1;
              end
            end
          end
        end
        S_WB, S_ERR: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign OP_READY  = r_ready;
  assign WB_VALID  = r_wb_vld;
  assign WB_RD     = r_wb_rd;
  assign WB_DATA   = r_wb_data;
  assign ERR       = r_err;
  assign CIM_REQ   = r_req;
  assign CIM_WRITE = r_strb.write;
  assign CIM_COMP  = r_strb.comp;
  assign CIM_PSUM  = r_strb.psum;
  assign CIM_RST   = r_strb.rst;
  assign CIM_OREG  = r_oreg;
  assign CIM_ADDR  = r_addr;
  assign CIM_DIN   = r_din;

endmodule

// File: tb/tb_cim_exec_unit.sv
// Directed self-checking bench for cim_exec_unit; inputs driven at negedge, outputs sampled at negedge.
module tb_cim_exec_unit;

  logic          CLK = 1'b0;
  logic          RES;
  logic          OP_VALID;
  logic          OP_READY;
  logic [2:0]    OP_FCT3;
  logic [31:0]   OP_RS1;
  logic [31:0]   OP_RS2;
  logic [4:0]    OP_RD;
  logic          WB_VALID;
  logic [4:0]    WB_RD;
  logic [31:0]   WB_DATA;
  logic          ERR;
  logic [3:0]    CIM_REQ;
  logic [3:0]    CIM_ACK;
  logic          CIM_WRITE, CIM_COMP, CIM_PSUM, CIM_RST;
  logic [3:0]    CIM_OREG;
  logic [11:0]   CIM_ADDR;
  logic [31:0]   CIM_DIN;
  logic [127:0]  CIM_DOUT;

  logic          auto_ack;
  logic [3:0]    manual_ack;
  int            checks = 0;
  int            errors = 0;

  assign CIM_ACK = auto_ack ? CIM_REQ : manual_ack;

  always #5 CLK = ~CLK;

  cim_exec_unit dut (
    .CLK(CLK), .RES(RES),
    .OP_VALID(OP_VALID), .OP_READY(OP_READY), .OP_FCT3(OP_FCT3),
    .OP_RS1(OP_RS1), .OP_RS2(OP_RS2), .OP_RD(OP_RD),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_DATA(WB_DATA), .ERR(ERR),
    .CIM_REQ(CIM_REQ), .CIM_ACK(CIM_ACK),
    .CIM_WRITE(CIM_WRITE), .CIM_COMP(CIM_COMP), .CIM_PSUM(CIM_PSUM), .CIM_RST(CIM_RST),
    .CIM_OREG(CIM_OREG), .CIM_ADDR(CIM_ADDR), .CIM_DIN(CIM_DIN), .CIM_DOUT(CIM_DOUT)
  );

  // Presents one instruction at a negedge; returns just after its accept edge E (in cycle E+1).
  // Operand buses are then scrambled so the DUT must have captured them.
  task automatic start_op(input logic [2:0] f, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [4:0] rd);
    @(negedge CLK);
    OP_VALID = 1'b1; OP_FCT3 = f; OP_RS1 = rs1; OP_RS2 = rs2; OP_RD = rd;
    @(posedge CLK);
    #1;
    OP_VALID = 1'b0; OP_RS1 = 32'hFFFF_FFFF; OP_RS2 = 32'hFFFF_FFFF; OP_RD = 5'h1F;
  endtask

  task automatic test_reset();
    RES = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({CIM_REQ, CIM_WRITE, CIM_COMP, CIM_PSUM, CIM_RST, CIM_OREG, CIM_ADDR, CIM_DIN} !== 56'd0) begin
      errors++;
      $display("FAIL reset_cim: got req=%b strb=%b%b%b%b oreg=%h addr=%h din=%h, expected all 0",
               CIM_REQ, CIM_WRITE, CIM_COMP, CIM_PSUM, CIM_RST, CIM_OREG, CIM_ADDR, CIM_DIN);
    end
    checks++;
    if ({OP_READY, WB_VALID, WB_RD, WB_DATA, ERR} !== 40'd0) begin
      errors++;
      $display("FAIL reset_ctl: got ready=%b wbv=%b wbrd=%0d wbdata=%h err=%b, expected all 0",
               OP_READY, WB_VALID, WB_RD, WB_DATA, ERR);
    end
    RES = 1'b1;
    @(negedge CLK);
    checks++;
    if (OP_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", OP_READY);
    end
  endtask

  task automatic test_write();
    auto_ack = 1'b1;
    start_op(3'b000, 32'hDEAD_BEEF, 32'h0000_2005, 5'd5);
    @(negedge CLK);  // E+1
    checks++;
    if ({CIM_REQ, CIM_WRITE, CIM_COMP, CIM_PSUM, CIM_RST} !== 8'b0100_1000) begin
      errors++;
      $display("FAIL wr_req: got req=%b strb=%b%b%b%b expected req=0100 strb=1000",
               CIM_REQ, CIM_WRITE, CIM_COMP, CIM_PSUM, CIM_RST);
    end
    checks++;
    if ({CIM_ADDR, CIM_DIN} !== {12'h005, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL wr_addr_din: got addr=%h din=%h expected 005 deadbeef", CIM_ADDR, CIM_DIN);
    end
    checks++;
    if ({OP_READY, WB_VALID} !== 2'b00) begin
      errors++;
      $display("FAIL wr_busy: got ready=%b wbv=%b expected 0 0", OP_READY, WB_VALID);
    end
    @(negedge CLK);  // E+2
    checks++;
    if ({OP_READY, WB_VALID, CIM_REQ, CIM_WRITE} !== 7'b1_0_0000_0) begin
      errors++;
      $display("FAIL wr_done: got ready=%b wbv=%b req=%b write=%b expected 1 0 0000 0",
               OP_READY, WB_VALID, CIM_REQ, CIM_WRITE);
    end
  endtask

  task automatic test_read_wait();
    auto_ack = 1'b0;
    manual_ack = 4'b0111;  // unselected banks acking must be ignored
    start_op(3'b010, 32'h0000_3010, 32'h0000_0000, 5'd7);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if ({CIM_REQ, CIM_ADDR, WB_VALID, OP_READY} !== {4'b1000, 12'h010, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rd_wait_%0d: got req=%b addr=%h wbv=%b ready=%b expected 1000 010 0 0",
                 i, CIM_REQ, CIM_ADDR, WB_VALID, OP_READY);
      end
      if (i == 3) manual_ack = 4'b1000;
    end
    @(posedge CLK);
    #1 manual_ack = 4'b0000;
    @(negedge CLK);
    checks++;
    if ({WB_VALID, WB_RD, WB_DATA, CIM_REQ} !== {1'b1, 5'd7, 32'h1234_5678, 4'b0000}) begin
      errors++;
      $display("FAIL rd_wb: got wbv=%b rd=%0d data=%h req=%b expected 1 7 12345678 0000",
               WB_VALID, WB_RD, WB_DATA, CIM_REQ);
    end
    @(negedge CLK);
    checks++;
    if ({WB_VALID, OP_READY} !== 2'b01) begin
      errors++;
      $display("FAIL rd_after_wb: got wbv=%b ready=%b expected 0 1", WB_VALID, OP_READY);
    end
  endtask

  task automatic test_burst_wrap();
    logic [11:0] exp_addr [4];
    exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'h000; exp_addr[3] = 12'h001;
    auto_ack = 1'b1;
    start_op(3'b101, 32'hCAFE_F00D, 32'h0300_0FFE, 5'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if ({CIM_REQ, CIM_ADDR, CIM_COMP, CIM_PSUM, CIM_DIN, OP_READY} !==
          {4'b0001, exp_addr[i], 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0}) begin
        errors++;
        $display("FAIL burst_beat_%0d: got req=%b addr=%h comp=%b psum=%b din=%h ready=%b expected 0001 %h 1 1 cafef00d 0",
                 i, CIM_REQ, CIM_ADDR, CIM_COMP, CIM_PSUM, CIM_DIN, OP_READY, exp_addr[i]);
      end
    end
    @(negedge CLK);  // E+5
    checks++;
    if ({OP_READY, CIM_REQ, WB_VALID} !== 6'b1_0000_0) begin
      errors++;
      $display("FAIL burst_done: got ready=%b req=%b wbv=%b expected 1 0000 0", OP_READY, CIM_REQ, WB_VALID);
    end
  endtask

  task automatic test_reg_ops();
    auto_ack = 1'b1;
    CIM_DOUT[63:32] = 32'h0000_0055;
    start_op(3'b011, 32'h0000_0009, 32'h0000_1000, 5'd0);
    @(negedge CLK);
    checks++;
    if ({CIM_REQ, CIM_OREG, CIM_WRITE, CIM_COMP, CIM_PSUM, CIM_RST} !== {4'b0010, 4'd9, 4'b0100}) begin
      errors++;
      $display("FAIL regrd_issue: got req=%b oreg=%0d strb=%b%b%b%b expected 0010 9 0100",
               CIM_REQ, CIM_OREG, CIM_WRITE, CIM_COMP, CIM_PSUM, CIM_RST);
    end
    @(negedge CLK);
    checks++;
    if ({WB_VALID, OP_READY, CIM_REQ} !== 6'b0_1_0000) begin
      errors++;
      $display("FAIL regrd_rd0_no_wb: got wbv=%b ready=%b req=%b expected 0 1 0000", WB_VALID, OP_READY, CIM_REQ);
    end
    start_op(3'b100, 32'h0000_0000, 32'h0000_3000, 5'd4);
    @(negedge CLK);
    checks++;
    if ({CIM_REQ, CIM_WRITE, CIM_COMP, CIM_PSUM, CIM_RST} !== 8'b1000_0101) begin
      errors++;
      $display("FAIL regrst_issue: got req=%b strb=%b%b%b%b expected 1000 0101",
               CIM_REQ, CIM_WRITE, CIM_COMP, CIM_PSUM, CIM_RST);
    end
    @(negedge CLK);
    checks++;
    if ({WB_VALID, OP_READY} !== 2'b01) begin
      errors++;
      $display("FAIL regrst_done: got wbv=%b ready=%b expected 0 1", WB_VALID, OP_READY);
    end
  endtask

  task automatic test_illegal();
    auto_ack = 1'b0;
    manual_ack = 4'b1111;
    start_op(3'b110, 32'h1111_1111, 32'h0000_2000, 5'd3);
    @(negedge CLK);  // E+1
    checks++;
    if ({ERR, CIM_REQ, OP_READY, WB_VALID} !== 7'b1_0000_0_0) begin
      errors++;
      $display("FAIL illegal_err: got err=%b req=%b ready=%b wbv=%b expected 1 0000 0 0",
               ERR, CIM_REQ, OP_READY, WB_VALID);
    end
    @(negedge CLK);  // E+2
    checks++;
    if ({ERR, CIM_REQ, OP_READY, WB_VALID} !== 7'b0_0000_1_0) begin
      errors++;
      $display("FAIL illegal_done: got err=%b req=%b ready=%b wbv=%b expected 0 0000 1 0",
               ERR, CIM_REQ, OP_READY, WB_VALID);
    end
    manual_ack = 4'b0000;
  endtask

  task automatic test_back_to_back();
    auto_ack = 1'b1;
    start_op(3'b000, 32'h0000_00AA, 32'h0000_1ABC, 5'd0);
    @(negedge CLK);
    checks++;
    if ({CIM_REQ, CIM_ADDR, CIM_WRITE} !== {4'b0010, 12'hABC, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first: got req=%b addr=%h write=%b expected 0010 abc 1", CIM_REQ, CIM_ADDR, CIM_WRITE);
    end
    start_op(3'b001, 32'h0000_0011, 32'h0000_2123, 5'd0);
    @(negedge CLK);
    checks++;
    if ({CIM_REQ, CIM_ADDR, CIM_DIN, CIM_WRITE, CIM_COMP, CIM_PSUM, CIM_RST} !==
        {4'b0100, 12'h123, 32'h0000_0011, 4'b0110}) begin
      errors++;
      $display("FAIL b2b_second: got req=%b addr=%h din=%h strb=%b%b%b%b expected 0100 123 00000011 0110",
               CIM_REQ, CIM_ADDR, CIM_DIN, CIM_WRITE, CIM_COMP, CIM_PSUM, CIM_RST);
    end
    @(negedge CLK);
    checks++;
    if (OP_READY !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b expected 1", OP_READY);
    end
  endtask

  task automatic test_reset_mid_burst();
    auto_ack = 1'b1;
    start_op(3'b101, 32'h0000_0077, 32'h0700_0100, 5'd9);
    @(negedge CLK);  // beat 1
    @(negedge CLK);  // beat 2
    checks++;
    if ({CIM_REQ, CIM_ADDR} !== {4'b0001, 12'h101}) begin
      errors++;
      $display("FAIL midrst_beat2: got req=%b addr=%h expected 0001 101", CIM_REQ, CIM_ADDR);
    end
    RES = 1'b0;
    @(negedge CLK);
    checks++;
    if ({CIM_REQ, CIM_WRITE, CIM_COMP, CIM_PSUM, CIM_RST, CIM_OREG, CIM_ADDR, CIM_DIN,
         OP_READY, WB_VALID, WB_RD, WB_DATA, ERR} !== 96'd0) begin
      errors++;
      $display("FAIL midrst_zero: got req=%b addr=%h din=%h ready=%b wbv=%b wbdata=%h err=%b expected all 0",
               CIM_REQ, CIM_ADDR, CIM_DIN, OP_READY, WB_VALID, WB_DATA, ERR);
    end
    RES = 1'b1;
    @(negedge CLK);
    checks++;
    if ({OP_READY, CIM_REQ} !== 5'b1_0000) begin
      errors++;
      $display("FAIL midrst_release: got ready=%b req=%b expected 1 0000", OP_READY, CIM_REQ);
    end
    start_op(3'b000, 32'h0BAD_CAFE, 32'h0000_3FFF, 5'd0);
    @(negedge CLK);
    checks++;
    if ({CIM_REQ, CIM_ADDR, CIM_DIN, CIM_WRITE} !== {4'b1000, 12'hFFF, 32'h0BAD_CAFE, 1'b1}) begin
      errors++;
      $display("FAIL midrst_newwr: got req=%b addr=%h din=%h write=%b expected 1000 fff 0badcafe 1",
               CIM_REQ, CIM_ADDR, CIM_DIN, CIM_WRITE);
    end
    @(negedge CLK);
    checks++;
    if ({OP_READY, WB_VALID, CIM_REQ} !== 6'b1_0_0000) begin
      errors++;
      $display("FAIL midrst_newwr_done: got ready=%b wbv=%b req=%b expected 1 0 0000", OP_READY, WB_VALID, CIM_REQ);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RES = 1'b0; OP_VALID = 1'b0; OP_FCT3 = 3'b000; OP_RS1 = '0; OP_RS2 = '0; OP_RD = '0;
    auto_ack = 1'b0; manual_ack = 4'b0000;
    CIM_DOUT = {32'h1234_5678, 32'hBBBB_2222, 32'h0000_0055, 32'hAAAA_0000};
    test_reset();
    test_write();
    test_read_wait();
    test_burst_wrap();
    test_reg_ops();
    test_illegal();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
